zedboard_reset_conditioner: RTL and testbench
=============================================

// Module: zedboard_reset_conditioner
// PURPOSE
//  Conditions the raw board reset push-button into a clean, stretched, active-low
//  SoC reset (rst_no) that drives pulpissimo pad_reset_n in the ZedBoard top level.
//  Flow: synchronise the asynchronous button, debounce it, then hold reset for a
//  fixed number of cycles after power-up and after every debounced release.
//  Sits between the button pad and the SoC instance, in the ref_clk domain.
// PARAMETERS
//  SYNC_STAGES      2      flip-flop stages in the btn_i synchroniser (>=2)
//  DEBOUNCE_CYCLES  500000 cycles a new btn level must be stable before it is accepted (>=2)
//  HOLD_CYCLES      1024   cycles rst_no stays low after power-up or button release (>=1)
// PORTS
//  clk_i      in   1  board reference clock (post-BUFG)
//  rst_i      in   1  synchronous, active-high block reset (e.g. ~MMCM locked)
//  btn_i      in   1  raw reset button, active-high, asynchronous, bouncing
//  rst_no     out  1  conditioned SoC reset, active-low, registered
//  btn_db_o   out  1  debounced button level, registered
//  state_o    out  2  FSM state, for ILA/debug
// BEHAVIOUR
//  Reset: rst_i is sampled on clk_i. While it is high, all state returns to reset values:
//    sync chain=0, deb_cnt=0, btn_db_o=0, hold_cnt=0, state=HOLD, rst_no=0.
//  rst_i asserted mid-operation: same result from the next edge on.
//    The hold period restarts from 0 after rst_i falls.
//  Synchroniser: btn_i passes through SYNC_STAGES flip-flops; the last stage is btn_s.
//  Debounce, per edge:
//    btn_s==btn_db_o                                  -> deb_cnt<=0
//    btn_s!=btn_db_o, deb_cnt<DEBOUNCE_CYCLES-1       -> deb_cnt++
//    btn_s!=btn_db_o, deb_cnt==DEBOUNCE_CYCLES-1      -> btn_db_o<=btn_s, deb_cnt<=0
//  Debounce counter: width $clog2(DEBOUNCE_CYCLES). It never wraps.
//    Any bounce back to btn_db_o clears it.
//  Latency: a clean btn_i step reaches btn_db_o SYNC_STAGES+DEBOUNCE_CYCLES edges
//    after the first edge that samples it.
//  Pulse filtering: pulses of DEBOUNCE_CYCLES-1 cycles or fewer never reach btn_db_o.
//  FSM (state_o: HOLD=2'd0, RUN=2'd1, PRESSED=2'd2; 2'd3 is illegal and goes to HOLD):
//    HOLD: rst_no=0; hold_cnt increments each edge.
//      btn_db_o==1                                -> PRESSED, hold_cnt<=0 (press wins over hold completion)
//      hold_cnt==HOLD_CYCLES-1                    -> RUN, rst_no<=1
//    RUN: rst_no=1.
//      btn_db_o==1                                -> PRESSED, rst_no<=0 (one edge after btn_db_o rises)
//    PRESSED: rst_no=0; hold_cnt held at 0.
//      btn_db_o==0                                -> HOLD
//  Consequences:
//    rst_no rises exactly HOLD_CYCLES edges after rst_i is deasserted, if the button is idle.
//    A button held through power-up keeps rst_no low until release+debounce+HOLD_CYCLES.
//  rst_no is registered and glitch-free; it changes only on a state transition.
//  hold_cnt width: $clog2(HOLD_CYCLES+1).
// STRUCTURE
//  Shared package fpga_board_pkg holds:
//    - state encoding localparams (ST_HOLD, ST_RUN, ST_PRESSED)
//    - default DEBOUNCE_CYCLES and HOLD_CYCLES for the 100 MHz ZedBoard clock
//  Sub-module fpga_debounce (synchroniser + debounce counter, outputs btn_db_o).
//    It is reused for the switch and button inputs.
//  The top contains only the FSM and hold counter.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
//  1 Power-up: rst_i=1 for 3 edges, then 0; btn_i=0
//      -> rst_no=0 for edges 1..7, rst_no=1 from edge 8; state_o 0->1.
//  2 Clean press in RUN: btn_i=1 from edge N
//      -> btn_db_o=1 at edge N+6, rst_no=0 at edge N+7.
//    Release btn_i=0 at edge M
//      -> btn_db_o=0 at M+6, state HOLD at M+7, rst_no=1 at M+15.
//  3 Glitch: btn_i=1 for 3 cycles, then 0 -> btn_db_o and rst_no never change.
//    Bounce pattern 1,1,0,1,1,1,1 -> deb_cnt clears on the 0; btn_db_o rises 4 edges after the last sync'd 0.
//  4 Button held during power-up: btn_i=1 before rst_i falls
//      -> PRESSED before hold completes; rst_no stays 0 until release + 6 + 8 edges.
//  5 Reset mid-operation: rst_i=1 for 1 edge while in RUN, and again while in PRESSED
//      -> next edge rst_no=0, btn_db_o=0, state_o=0; rst_no=1 exactly 8 edges after rst_i falls.
//  6 Simultaneous: btn_db_o rises on the same edge hold_cnt==7 -> state PRESSED, rst_no stays 0.

Source files
------------

// File: rtl/fpga_board_pkg.sv
// Shared ZedBoard definitions: reset-conditioner state encoding and default timing
// for the 100 MHz board reference clock.
package fpga_board_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PRESSED = 2'd2
  } state_e;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  // 5 ms of stability at 100 MHz before a button level is believed
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_HOLD_CYCLES     = 1024;

endpackage

// File: rtl/fpga_debounce.sv
// Synchroniser plus debounce counter for an asynchronous, bouncing board input;
// btn_db_o only follows the input after it has been stable for DEBOUNCE_CYCLES edges.
module fpga_debounce
  import fpga_board_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_db_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;

  assign btn_s    = sync_q[SYNC_STAGES-1];
  assign btn_db_o = db_q;

  // Any sample agreeing with the accepted level restarts the stability count,
  // so the counter can never wrap past CNT_LAST.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (btn_s != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = btn_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

endmodule

// File: rtl/zedboard_reset_conditioner.sv
// Turns the ZedBoard reset button into a clean, stretched active-low SoC reset:
// debounced button plus a hold period after power-up and after every release.
module zedboard_reset_conditioner
  import fpga_board_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  output logic       rst_no,
  output logic       btn_db_o,
  output logic [1:0] state_o
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              btn_db;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rst_n_q, rst_n_d;

  fpga_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_i),
    .btn_db_o(btn_db)
  );

  assign btn_db_o = btn_db;
  assign state_o  = state_q;
  assign rst_no   = rst_n_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      rst_n_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_n_q    <= rst_n_d;
    end
  end

  // A press always wins over hold completion so the SoC never sees a short release.
  always_comb begin
    state_d = ST_HOLD;
    case (state_q)
      ST_HOLD: begin
        if (btn_db)                        state_d = ST_PRESSED;
        else if (hold_cnt_q == HOLD_LAST)  state_d = ST_RUN;
        else                               state_d = ST_HOLD;
      end
      ST_RUN:     state_d = btn_db ? ST_PRESSED : ST_RUN;
      ST_PRESSED: state_d = btn_db ? ST_PRESSED : ST_HOLD;
      default:    state_d = ST_HOLD;
    endcase
  end

  // Reset output is registered from the next state, so it moves only on transitions.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == ST_HOLD && state_d == ST_HOLD) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    rst_n_d = (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_zedboard_reset_conditioner.sv
// Scoreboard bench for zedboard_reset_conditioner: a behavioural model predicts
// every edge's outputs into a queue that a negedge monitor drains and compares.
module tb_zedboard_reset_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       btn_i = 1'b0;
  logic       rst_no;
  logic       btn_db_o;
  logic [1:0] state_o;

  typedef struct packed {
    logic       rstN;
    logic       db;
    logic [1:0] st;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  bit   samples[$];
  int   streak;
  bit   mDb;
  int   mState;
  int   mHoldEdges;

  zedboard_reset_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_i),
    .rst_no  (rst_no),
    .btn_db_o(btn_db_o),
    .state_o (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: btn_s is the input sampled SYNC edges earlier; the level is accepted after
  // DEB consecutive disagreeing samples; the FSM reacts to the previous accepted level.
  task automatic modelEdge(input bit btn, input bit rst);
    bit   used;
    bit   oldDb;
    exp_t e;
    if (rst) begin
      samples.delete();
      streak     = 0;
      mDb        = 1'b0;
      mState     = 0;
      mHoldEdges = 0;
    end else begin
      oldDb = mDb;
      used  = (samples.size() >= SYNC) ? samples[samples.size() - SYNC] : 1'b0;
      samples.push_back(btn);
      if (used == mDb) begin
        streak = 0;
      end else begin
        streak++;
        if (streak == DEB) begin
          mDb    = used;
          streak = 0;
        end
      end
      case (mState)
        0: begin
          if (oldDb) begin
            mState     = 2;
            mHoldEdges = 0;
          end else begin
            mHoldEdges++;
            if (mHoldEdges == HOLD) mState = 1;
          end
        end
        1: if (oldDb) mState = 2;
        default: begin
          if (!oldDb) begin
            mState     = 0;
            mHoldEdges = 0;
          end
        end
      endcase
    end
    e.rstN = (mState == 1);
    e.db   = mDb;
    e.st   = 2'(mState);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit btn, input bit rst, input int n);
    repeat (n) begin
      #1;
      btn_i = btn;
      rst_i = rst;
      @(posedge clk_i);
      modelEdge(btn, rst);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rst_no", {1'b0, rst_no}, {1'b0, e.rstN});
      checkOutput("btn_db_o", {1'b0, btn_db_o}, {1'b0, e.db});
      checkOutput("state_o", state_o, e.st);
    end
  end

  initial begin
    // power-up with idle button
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 12);
    // clean press and release from RUN
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 20);
    // short glitch, then bounce pattern 1,1,0,1,1,1,1
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 20);
    // button held through power-up
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 15);
    applyStimulus(1'b0, 1'b0, 20);
    // reset pulse while in RUN, then while in PRESSED
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 12);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 12);
    // debounced press lands on the last hold edge
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 20);
    // randomized mix of resets, bounces and steady levels
    for (int s = 0; s < 120; s++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        applyStimulus(1'b0, 1'b1, int'($urandom_range(1, 2)));
      end else if (kind < 4) begin
        repeat (int'($urandom_range(2, 6)))
          applyStimulus(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 3)));
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 14)));
      end
    end
    applyStimulus(1'b0, 1'b0, 20);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("queue_drained", {1'b0, expQ.size() == 0}, 2'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
